// File: rtl/tick_countdown_timer.sv
// tick_countdown_timer: prescaled countdown timer driven by a single-cycle tick strobe.
// A prescaler folds PRESCALE ticks into one count unit; expiry gives a one-cycle done
// pulse plus a sticky expired flag.
// Optional build macro TICK_TIMER_AUTO_RELOAD_EN: expiry in RUN reloads the last started
// value and keeps running (periodic mode). Undefined gives single-shot behaviour.
module tick_countdown_timer #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PRESCALE = 20,
    parameter int unsigned PRE_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             expired
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_e;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [PRE_W-1:0]   pre_q,   pre_d;
    logic               done_q,  done_d;
    logic               expired_q, expired_d;
    logic               busy_q,  busy_d;
`ifdef TICK_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0]   reload_q, reload_d;
`endif

    logic load_zero;
    logic unit_end;
    logic last_unit;

    // Shared decode: zero load, prescaler wrap on this tick, final count unit.
    assign load_zero = (load_val == '0);
    assign unit_end  = tick && (pre_q == PRE_LAST);
    assign last_unit = (count_q <= WIDTH'(1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, priority clear > start > pause > tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_EXPIRED: begin
                if (clear)      state_d = S_IDLE;
                else if (start) state_d = load_zero ? S_EXPIRED : S_RUN;
            end
            S_RUN: begin
                if (clear)      state_d = S_IDLE;
                else if (start) state_d = load_zero ? S_EXPIRED : S_RUN;
                else if (pause) state_d = S_PAUSED;
`ifdef TICK_TIMER_AUTO_RELOAD_EN
                else if (unit_end && last_unit) state_d = S_RUN;
`else
                else if (unit_end && last_unit) state_d = S_EXPIRED;
`endif
            end
            S_PAUSED: begin
                if (clear)      state_d = S_IDLE;
                else if (start) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values; resume from PAUSED leaves count/prescaler intact.
    always_comb begin
        count_d   = count_q;
        pre_d     = pre_q;
        done_d    = 1'b0;
        expired_d = expired_q;
        busy_d    = (state_d == S_RUN) || (state_d == S_PAUSED);
`ifdef TICK_TIMER_AUTO_RELOAD_EN
        reload_d  = reload_q;
`endif
        if (clear) begin
            count_d   = '0;
            pre_d     = '0;
            expired_d = 1'b0;
        end else if (start && (state_q != S_PAUSED)) begin
            pre_d = '0;
            if (load_zero) begin
                count_d   = '0;
                done_d    = 1'b1;
                expired_d = 1'b1;
            end else begin
                count_d   = load_val;
                expired_d = 1'b0;
`ifdef TICK_TIMER_AUTO_RELOAD_EN
                reload_d  = load_val;
`endif
            end
        end else if ((state_q == S_RUN) && !pause && tick) begin
            if (pre_q != PRE_LAST) begin
                pre_d = pre_q + PRE_W'(1);
            end else begin
                pre_d = '0;
                if (last_unit) begin
`ifdef TICK_TIMER_AUTO_RELOAD_EN
                    count_d = reload_q;
`else
                    count_d = '0;
`endif
                    done_d    = 1'b1;
                    expired_d = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            pre_q     <= '0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef TICK_TIMER_AUTO_RELOAD_EN
            reload_q  <= '0;
`endif
        end else begin
            count_q   <= count_d;
            pre_q     <= pre_d;
            done_q    <= done_d;
            expired_q <= expired_d;
            busy_q    <= busy_d;
`ifdef TICK_TIMER_AUTO_RELOAD_EN
            reload_q  <= reload_d;
`endif
        end
    end

    assign count   = count_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign expired = expired_q;

endmodule

// File: doc/tick_countdown_timer.md
Name: tick_countdown_timer

Overview:
- Programmable countdown timer that consumes the single-cycle tick pulse from the LFSR tick generator, one tick per 0.05 ms.
- A prescaler converts PRESCALE ticks into one count unit. With the default of 20, one unit is 1 ms.
- Counts down from a loaded value. Reports expiry with a one-cycle done pulse and a sticky expired flag.
- Sits between the tick generator and control FSMs that need millisecond-scale timeouts.

Parameters:
- WIDTH, 16: width of load_val and count, in count units.
- PRESCALE, 20: ticks per count unit. Must be ≥1. PRESCALE=1 means every tick decrements.
- PRE_W, 5: prescaler counter width. Must satisfy 2^PRE_W ≥ PRESCALE.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. rst=0 forces the reset state immediately, regardless of clk.
- tick  input  1  one-cycle tick strobe from the upstream LFSR timer.
- load_val  input  WIDTH  start value, sampled on start.
- start  input  1  load and run. From PAUSED, resume instead.
- pause  input  1  freeze count and prescaler.
- clear  input  1  abort and return to IDLE.
- count  output  WIDTH  current remaining units, registered.
- busy  output  1  high in RUN and PAUSED.
- done  output  1  one-cycle pulse on expiry.
- expired  output  1  sticky; set on expiry, cleared by clear or start.

Behaviour:
- Reset state: state=IDLE, count=0, prescaler=0, busy=0, done=0, expired=0.
- Input priority, evaluated each cycle: clear > start > pause > tick.
- All outputs are registered. done, expired and count reflect an event in the cycle after the clock edge that sampled it.
- done defaults to 0 every cycle unless set by an expiry.
- IDLE:
  - start with load_val≠0: count<=load_val, prescaler<=0, go to RUN.
  - start with load_val=0: count<=0, done<=1, expired<=1, go to EXPIRED.
  - tick and pause are ignored.
- RUN:
  - clear: count<=0, prescaler<=0, go to IDLE.
  - start: reload from load_val, same rules as IDLE (restart).
  - pause: go to PAUSED. A tick arriving in the same cycle is discarded.
  - tick with prescaler<PRESCALE-1: prescaler increments.
  - tick with prescaler=PRESCALE-1: prescaler<=0, then:
    - count>1: count decrements.
    - count=1: count<=0, done<=1, expired<=1, go to EXPIRED.
  - No tick: hold.
- PAUSED:
  - count and prescaler hold; ticks are ignored.
  - start: resume to RUN with no reload. The prescaler keeps its partial value.
  - clear: go to IDLE.
- EXPIRED:
  - count=0, expired=1; ticks are ignored.
  - start: reload as from IDLE and clear expired.
  - clear: go to IDLE and clear expired.
- Timing: the first decrement occurs on the PRESCALE-th tick after start. The total time to expiry is load_val×PRESCALE ticks.
- count never wraps below 0. Maximum load is 2^WIDTH-1.
- Reset mid-operation: immediate return to the reset state. A done pulse in flight is dropped.
- busy = (state==RUN or state==PAUSED), registered alongside state.

Optional Feature:
- Macro: TICK_TIMER_AUTO_RELOAD_EN.
- Defined:
  - Expiry in RUN reloads count from the last started value, held in an internal reload register captured on start.
  - Timer stays in RUN, pulses done, and sets expired.
  - This gives a periodic timer with one done pulse every reload×PRESCALE ticks.
  - A start with load_val=0 still goes to EXPIRED; it does not reload.
- Undefined: single-shot behaviour as specified above. The reload register is not synthesized.

Test Plan:
1. Reset/async: assert rst=0 mid-RUN, between clock edges -> count=0, busy=0, expired=0 immediately, with no clock edge required.
2. Basic countdown, PRESCALE=4, load_val=3, tick every cycle after start -> count steps 3→2→1→0 every 4 ticks. A single done pulse follows the 12th tick; expired=1; busy=0.
3. Pause/resume, PRESCALE=4, load_val=2:
   - After 5 ticks assert pause, then apply 10 ticks -> count=1 held.
   - start resumes -> done follows 3 further ticks (8 total counted).
4. Priority/zero load:
   - Same-cycle clear+start in RUN -> IDLE, count=0.
   - start with load_val=0 -> done pulse next cycle, expired=1, no ticks needed.
   - pause+tick in the same cycle -> tick discarded, prescaler unchanged.
5. Restart while running: load_val=5, after 1 unit start again with load_val=2 -> count=2, prescaler=0, expiry after 2×PRESCALE further ticks.
6. TICK_TIMER_AUTO_RELOAD_EN, PRESCALE=1, load_val=3 -> done pulses every 3 ticks for 3 consecutive periods. State stays RUN and count reloads to 3 each period.
